// File: rtl/planta_irrigacao.sv
// Behavioural irrigation plant: integrates actuator commands into a reservoir
// level counter and a soil humidity counter, and drives the sensor signals
// derived from them.
// Ports:
//   Clock, Reset            rising-edge clock, synchronous active-low reset
//   Ve, Bs, Bs_Ag, Vs       actuator commands (inlet, sprinkler, agro pump, outlet)
//   Ua_chave/T_chave/Ag_chave  raw operator switches (asynchronous)
//   Falha, Limpa            fault injection, sticky-flag clear
//   H, M, L, Us             registered level / soil sensors
//   Ua, T, Ag               synchronised switches
//   Transbordo, Seco        sticky overflow / dry-pump flags
//   nivel                   current level register
module planta_irrigacao #(
    parameter int unsigned LEVEL_W    = 8,
    parameter int unsigned LEVEL_MAX  = 255,
    parameter int unsigned INIT_LEVEL = 0,
    parameter int unsigned TICK_DIV   = 1,
    parameter int unsigned FILL_RATE  = 4,
    parameter int unsigned DRAIN_RATE = 2,
    parameter int unsigned VS_RATE    = 8,
    parameter int unsigned L_TH       = 32,
    parameter int unsigned M_TH       = 128,
    parameter int unsigned H_TH       = 224,
    parameter int unsigned IRR_RATE   = 3,
    parameter int unsigned DRY_RATE   = 1,
    parameter int unsigned SOIL_OK_TH = 24
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Ve,
    input  logic               Bs,
    input  logic               Bs_Ag,
    input  logic               Vs,
    input  logic               Ua_chave,
    input  logic               T_chave,
    input  logic               Ag_chave,
    input  logic               Falha,
    input  logic               Limpa,
    output logic               H,
    output logic               M,
    output logic               L,
    output logic               Us,
    output logic               Ua,
    output logic               T,
    output logic               Ag,
    output logic               Transbordo,
    output logic               Seco,
    output logic [LEVEL_W-1:0] nivel
);

    localparam int unsigned SW    = LEVEL_W + 2;
    localparam int unsigned HW    = LEVEL_W + 1;
    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LEVEL_W-1:0] hum_q, hum_d;
    logic               h_q, h_d, m_q, m_d, l_q, l_d, us_q, us_d;
    logic               trans_q, trans_d, seco_q, seco_d;
    logic [2:0]         sw1_q, sw1_d, sw2_q, sw2_d;

    logic               tick;
    logic               pump;
    logic signed [SW-1:0] lvl_sum;
    logic [HW-1:0]      hum_sum;

    // Model tick generation and counter integration
    always_comb begin
        tick    = (pre_q == PRE_W'(TICK_DIV - 1));
        pre_d   = tick ? '0 : pre_q + PRE_W'(1);
        pump    = Bs | Bs_Ag;

        // Net all commands in a signed domain wide enough for both overshoots
        lvl_sum = $signed({2'b00, level_q});
        if (Ve)   lvl_sum = lvl_sum + $signed(SW'(FILL_RATE));
        if (pump) lvl_sum = lvl_sum - $signed(SW'(DRAIN_RATE));
        if (Vs)   lvl_sum = lvl_sum - $signed(SW'(VS_RATE));

        level_d = level_q;
        if (tick) begin
            if (lvl_sum < $signed(SW'(0)))
                level_d = '0;
            else if (lvl_sum > $signed(SW'(LEVEL_MAX)))
                level_d = LEVEL_W'(LEVEL_MAX);
            else
                level_d = lvl_sum[LEVEL_W-1:0];
        end

        hum_sum = {1'b0, hum_q} + HW'(IRR_RATE);
        hum_d   = hum_q;
        if (tick) begin
            if (pump)
                hum_d = hum_sum[LEVEL_W] ? '1 : hum_sum[LEVEL_W-1:0];
            else if (hum_q < LEVEL_W'(DRY_RATE))
                hum_d = '0;
            else
                hum_d = hum_q - LEVEL_W'(DRY_RATE);
        end

        // Set has priority over clear
        trans_d = (tick & Ve & (lvl_sum > $signed(SW'(LEVEL_MAX)))) | (trans_q & ~Limpa);
        seco_d  = (tick & pump & (level_q == '0)) | (seco_q & ~Limpa);

        // Sensors follow the counters one cycle later; Falha forces H=1, L=0
        h_d  = Falha | (level_q >= LEVEL_W'(H_TH));
        m_d  = (level_q >= LEVEL_W'(M_TH));
        l_d  = ~Falha & (level_q >= LEVEL_W'(L_TH));
        us_d = (hum_q >= LEVEL_W'(SOIL_OK_TH));

        sw1_d = {Ag_chave, T_chave, Ua_chave};
        sw2_d = sw1_q;
    end

    // State registers
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            pre_q   <= '0;
            level_q <= LEVEL_W'(INIT_LEVEL);
            hum_q   <= '0;
            h_q     <= 1'b0;
            m_q     <= 1'b0;
            l_q     <= 1'b0;
            us_q    <= 1'b0;
            trans_q <= 1'b0;
            seco_q  <= 1'b0;
            sw1_q   <= '0;
            sw2_q   <= '0;
        end else begin
            pre_q   <= pre_d;
            level_q <= level_d;
            hum_q   <= hum_d;
            h_q     <= h_d;
            m_q     <= m_d;
            l_q     <= l_d;
            us_q    <= us_d;
            trans_q <= trans_d;
            seco_q  <= seco_d;
            sw1_q   <= sw1_d;
            sw2_q   <= sw2_d;
        end
    end

    assign H          = h_q;
    assign M          = m_q;
    assign L          = l_q;
    assign Us         = us_q;
    assign Ua         = sw2_q[0];
    assign T          = sw2_q[1];
    assign Ag         = sw2_q[2];
    assign Transbordo = trans_q;
    assign Seco       = seco_q;
    assign nivel      = level_q;

endmodule

// File: tb/tb_planta_irrigacao.sv
// Directed bench for planta_irrigacao: one instance with TICK_DIV=1 and one
// with TICK_DIV=4 sharing the command inputs but with separate resets.
module tb_planta_irrigacao;

    logic       clk = 1'b0;
    logic       rst_n, rst4_n;
    logic       ve, bs, bs_ag, vs, ua_ch, t_ch, ag_ch, falha, limpa;
    logic       h, m, l, us, ua, t, ag, trans, seco;
    logic [7:0] nivel;
    logic       h4, m4, l4, us4, ua4, t4, ag4, trans4, seco4;
    logic [7:0] nivel4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    planta_irrigacao dut (
        .Clock(clk), .Reset(rst_n), .Ve(ve), .Bs(bs), .Bs_Ag(bs_ag), .Vs(vs),
        .Ua_chave(ua_ch), .T_chave(t_ch), .Ag_chave(ag_ch), .Falha(falha), .Limpa(limpa),
        .H(h), .M(m), .L(l), .Us(us), .Ua(ua), .T(t), .Ag(ag),
        .Transbordo(trans), .Seco(seco), .nivel(nivel)
    );

    planta_irrigacao #(.TICK_DIV(4)) dut4 (
        .Clock(clk), .Reset(rst4_n), .Ve(ve), .Bs(bs), .Bs_Ag(bs_ag), .Vs(vs),
        .Ua_chave(ua_ch), .T_chave(t_ch), .Ag_chave(ag_ch), .Falha(falha), .Limpa(limpa),
        .H(h4), .M(m4), .L(l4), .Us(us4), .Ua(ua4), .T(t4), .Ag(ag4),
        .Transbordo(trans4), .Seco(seco4), .nivel(nivel4)
    );

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ve = 0; bs = 0; bs_ag = 0; vs = 0; falha = 0; limpa = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        clk_n(1);
        rst_n = 1;
    endtask

    task automatic test_reset();
        ve = 1; bs = 1; falha = 1; limpa = 0; rst_n = 0;
        clk_n(2);
        n_cmp++; if (nivel !== 8'd0) begin n_err++; $display("FAIL reset_nivel got %0d want 0", nivel); end
        n_cmp++; if ({h, m, l, us, ua, t, ag, trans, seco} !== 9'b0)
            begin n_err++; $display("FAIL reset_bits got %b want 000000000", {h, m, l, us, ua, t, ag, trans, seco}); end
        clear_inputs();
        rst_n = 1;
    endtask

    task automatic test_fill_l();
        do_reset();
        ve = 1;
        clk_n(8);
        n_cmp++; if (nivel !== 8'd32) begin n_err++; $display("FAIL fill_nivel got %0d want 32", nivel); end
        n_cmp++; if (l !== 1'b0) begin n_err++; $display("FAIL fill_l_early got %b want 0", l); end
        ve = 0;
        clk_n(1);
        n_cmp++; if ({h, m, l} !== 3'b001) begin n_err++; $display("FAIL fill_hml got %b want 001", {h, m, l}); end
    endtask

    task automatic test_overflow();
        do_reset();
        ve = 1;
        clk_n(56);
        n_cmp++; if (nivel !== 8'd224) begin n_err++; $display("FAIL ovf_nivel56 got %0d want 224", nivel); end
        n_cmp++; if (h !== 1'b0) begin n_err++; $display("FAIL ovf_h56 got %b want 0", h); end
        clk_n(1);
        n_cmp++; if (h !== 1'b1) begin n_err++; $display("FAIL ovf_h57 got %b want 1", h); end
        clk_n(6);
        n_cmp++; if (nivel !== 8'd252) begin n_err++; $display("FAIL ovf_nivel63 got %0d want 252", nivel); end
        n_cmp++; if (trans !== 1'b0) begin n_err++; $display("FAIL ovf_trans63 got %b want 0", trans); end
        clk_n(1);
        n_cmp++; if (nivel !== 8'd255) begin n_err++; $display("FAIL ovf_nivel64 got %0d want 255", nivel); end
        n_cmp++; if (trans !== 1'b1) begin n_err++; $display("FAIL ovf_trans64 got %b want 1", trans); end
        limpa = 1;
        clk_n(1);
        n_cmp++; if (trans !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins got %b want 1", trans); end
        ve = 0; limpa = 0;
        clk_n(3);
        n_cmp++; if (trans !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", trans); end
        n_cmp++; if (nivel !== 8'd255) begin n_err++; $display("FAIL ovf_hold got %0d want 255", nivel); end
        limpa = 1;
        clk_n(1);
        n_cmp++; if (trans !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", trans); end
        limpa = 0;
    endtask

    task automatic test_net_humidity();
        do_reset();
        ve = 1;
        clk_n(25);
        n_cmp++; if (nivel !== 8'd100) begin n_err++; $display("FAIL net_start got %0d want 100", nivel); end
        bs = 1; vs = 1;
        clk_n(5);
        n_cmp++; if (nivel !== 8'd70) begin n_err++; $display("FAIL net_nivel got %0d want 70", nivel); end
        n_cmp++; if (us !== 1'b0) begin n_err++; $display("FAIL net_us15 got %b want 0", us); end
        ve = 0; vs = 0;
        clk_n(3);
        n_cmp++; if (nivel !== 8'd64) begin n_err++; $display("FAIL net_bs_only got %0d want 64", nivel); end
        n_cmp++; if (us !== 1'b0) begin n_err++; $display("FAIL net_us_lat got %b want 0", us); end
        bs = 0;
        clk_n(1);
        n_cmp++; if (us !== 1'b1) begin n_err++; $display("FAIL net_us24 got %b want 1", us); end
        n_cmp++; if (seco !== 1'b0) begin n_err++; $display("FAIL net_seco got %b want 0", seco); end
    endtask

    task automatic test_dry_clamp();
        do_reset();
        ve = 1;
        clk_n(1);
        n_cmp++; if (nivel !== 8'd4) begin n_err++; $display("FAIL dry_start got %0d want 4", nivel); end
        ve = 0; vs = 1; bs = 1;
        clk_n(1);
        n_cmp++; if (nivel !== 8'd0) begin n_err++; $display("FAIL dry_clamp got %0d want 0", nivel); end
        n_cmp++; if (seco !== 1'b0) begin n_err++; $display("FAIL dry_seco_early got %b want 0", seco); end
        vs = 0;
        clk_n(1);
        n_cmp++; if (seco !== 1'b1) begin n_err++; $display("FAIL dry_seco got %b want 1", seco); end
        n_cmp++; if (nivel !== 8'd0) begin n_err++; $display("FAIL dry_stay0 got %0d want 0", nivel); end
        bs = 0; limpa = 1;
        clk_n(1);
        n_cmp++; if (seco !== 1'b0) begin n_err++; $display("FAIL dry_clear got %b want 0", seco); end
        limpa = 0;
    endtask

    task automatic test_falha();
        do_reset();
        ve = 1;
        clk_n(36);
        bs = 1;
        clk_n(3);
        n_cmp++; if (nivel !== 8'd150) begin n_err++; $display("FAIL falha_start got %0d want 150", nivel); end
        ve = 0; bs = 0; falha = 1;
        clk_n(1);
        n_cmp++; if ({h, m, l} !== 3'b110) begin n_err++; $display("FAIL falha_on got %b want 110", {h, m, l}); end
        n_cmp++; if (nivel !== 8'd150) begin n_err++; $display("FAIL falha_nivel got %0d want 150", nivel); end
        falha = 0;
        clk_n(1);
        n_cmp++; if ({h, m, l} !== 3'b011) begin n_err++; $display("FAIL falha_off got %b want 011", {h, m, l}); end
    endtask

    task automatic test_switches();
        ua_ch = 1; t_ch = 1;
        clk_n(1);
        n_cmp++; if (ua !== 1'b0) begin n_err++; $display("FAIL sw_ua_1cyc got %b want 0", ua); end
        clk_n(1);
        n_cmp++; if ({ua, t, ag} !== 3'b110) begin n_err++; $display("FAIL sw_2cyc got %b want 110", {ua, t, ag}); end
        ua_ch = 0; ag_ch = 1;
        clk_n(1);
        n_cmp++; if ({ua, ag} !== 2'b10) begin n_err++; $display("FAIL sw_fall_1cyc got %b want 10", {ua, ag}); end
        clk_n(1);
        n_cmp++; if ({ua, ag} !== 2'b01) begin n_err++; $display("FAIL sw_fall_2cyc got %b want 01", {ua, ag}); end
        t_ch = 0; ag_ch = 0;
    endtask

    task automatic test_tick_div();
        clear_inputs();
        rst4_n = 0; ve = 1;
        clk_n(1);
        rst4_n = 1;
        clk_n(3);
        n_cmp++; if (nivel4 !== 8'd0) begin n_err++; $display("FAIL div_pre_tick got %0d want 0", nivel4); end
        clk_n(1);
        n_cmp++; if (nivel4 !== 8'd4) begin n_err++; $display("FAIL div_first got %0d want 4", nivel4); end
        clk_n(44);
        n_cmp++; if (nivel4 !== 8'd48) begin n_err++; $display("FAIL div_48 got %0d want 48", nivel4); end
        clk_n(2);
        n_cmp++; if (nivel4 !== 8'd48) begin n_err++; $display("FAIL div_midcount got %0d want 48", nivel4); end
        rst4_n = 0;
        clk_n(1);
        n_cmp++; if (nivel4 !== 8'd0) begin n_err++; $display("FAIL div_reset got %0d want 0", nivel4); end
        rst4_n = 1;
        clk_n(3);
        n_cmp++; if (nivel4 !== 8'd0) begin n_err++; $display("FAIL div_restart got %0d want 0", nivel4); end
        clk_n(1);
        n_cmp++; if (nivel4 !== 8'd4) begin n_err++; $display("FAIL div_restart_inc got %0d want 4", nivel4); end
        ve = 0;
    endtask

    initial begin
        rst_n = 0; rst4_n = 0;
        ua_ch = 0; t_ch = 0; ag_ch = 0;
        clear_inputs();
        clk_n(2);
        test_reset();
        test_fill_l();
        test_overflow();
        test_net_humidity();
        test_dry_clamp();
        test_falha();
        test_switches();
        test_tick_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
